// File: rtl/fft2d_pass_selecter.sv
// fft2d_pass_selecter: registered row/column pass selector feeding the 2-D FFT butterfly array
module fft2d_pass_selecter #(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*N*2*DW-1:0]   in_data,
    input  logic                  rt_valid,
    input  logic [N*N*2*DW-1:0]   rt_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*N*2*DW-1:0]   out_data,
    output logic                  out_pass,
    output logic                  done,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic                  rt_err
);
    localparam int EW = 2 * DW;
    typedef enum logic [1:0] {IDLE, ROW_OUT, WAIT_RT, COL_OUT} state_t;
    state_t state, next_state;
    logic [N*N*EW-1:0] fbuf, rt_t;
    logic in_acc, rt_acc, col_acc;
    for (genvar r = 0; r < N; r++) begin : g_r
        for (genvar c = 0; c < N; c++) begin : g_c
            assign rt_t[(r*N+c)*EW +: EW] = rt_data[(c*N+r)*EW +: EW];
        end
    end
    assign in_ready = (state == IDLE) && !reset;
    assign out_data = fbuf;
    always_comb begin
        in_acc     = (state == IDLE) && in_valid;
        rt_acc     = (state == WAIT_RT) && rt_valid;
        col_acc    = (state == COL_OUT) && out_ready;
        next_state = in_acc ? ROW_OUT :
                     ((state == ROW_OUT) && out_ready) ? WAIT_RT :
                     rt_acc ? COL_OUT :
                     col_acc ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fbuf      <= '0;
            out_valid <= 1'b0;
            out_pass  <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
            rt_err    <= 1'b0;
        end else begin
            state     <= next_state;
            fbuf      <= in_acc ? in_data : rt_acc ? rt_t : fbuf;
            out_pass  <= in_acc ? 1'b0 : rt_acc ? 1'b1 : out_pass;
            out_valid <= (next_state == ROW_OUT) || (next_state == COL_OUT);
            done      <= col_acc;
            frame_cnt <= frame_cnt + CNT_W'(col_acc);
            rt_err    <= rt_err | (rt_valid && (state != WAIT_RT));
        end
    end
endmodule

// File: tb/tb_fft2d_pass_selecter.sv
// tb_fft2d_pass_selecter: randomized self-checking bench with an element-array transpose model
module tb_fft2d_pass_selecter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 2;
    localparam int FW = N*N*2*DW;
    logic clk = 0, reset = 1, in_valid = 0, rt_valid = 0, out_ready = 0;
    logic [FW-1:0] in_data = '0, rt_data = '0;
    logic in_ready, out_valid, out_pass, done, rt_err;
    logic [FW-1:0] out_data;
    logic [CW-1:0] frame_cnt;
    int n_chk = 0, n_fail = 0, n_done = 0, exp_cnt = 0;
    bit exp_err = 0;

    fft2d_pass_selecter #(.N(N), .DW(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rt_valid(rt_valid), .rt_data(rt_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pass(out_pass), .done(done), .frame_cnt(frame_cnt), .rt_err(rt_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) n_done++;

    function automatic logic [FW-1:0] xpose(input logic [FW-1:0] f);
        logic [DW-1:0] re [N][N];
        logic [DW-1:0] im [N][N];
        logic [FW-1:0] t;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                re[r][c] = f[(2*(r*N+c))*DW +: DW];
                im[r][c] = f[(2*(r*N+c)+1)*DW +: DW];
            end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                t[(2*(r*N+c))*DW +: DW]   = re[c][r];
                t[(2*(r*N+c)+1)*DW +: DW] = im[c][r];
            end
        return t;
    endfunction

    function automatic logic [FW-1:0] rnd_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW/32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [FW-1:0] f, input logic [FW-1:0] rt, input int bp, input bit stray);
        int w = 0;
        logic [FW-1:0] xt = xpose(rt);
        while (!in_ready && w < 20) begin cyc(); w++; end
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_wait: got %b want 1", in_ready); end
        in_valid = 1; in_data = f;
        cyc();
        in_valid = 0;
        n_chk++;
        if (out_valid !== 1'b1 || out_pass !== 1'b0 || out_data !== f) begin
            n_fail++; $display("FAIL row_out: valid=%b pass=%b data=%h want 1 0 %h", out_valid, out_pass, out_data, f);
        end
        for (int i = 0; i < bp; i++) begin
            if (stray && i == 0) begin rt_valid = 1; rt_data = ~rt; exp_err = 1; end
            in_valid = i[0]; in_data = rnd_frame();
            cyc();
            rt_valid = 0; in_valid = 0;
            n_chk++;
            if (out_valid !== 1'b1 || out_pass !== 1'b0 || out_data !== f || done !== 1'b0 || rt_err !== exp_err) begin
                n_fail++; $display("FAIL row_hold: valid=%b pass=%b done=%b err=%b data=%h want 1 0 0 %b %h",
                                   out_valid, out_pass, done, rt_err, out_data, exp_err, f);
            end
        end
        out_ready = 1;
        cyc();
        out_ready = 0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL wait_rt: valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        rt_valid = 1; rt_data = rt;
        cyc();
        rt_valid = 0;
        n_chk++;
        if (out_valid !== 1'b1 || out_pass !== 1'b1 || out_data !== xt) begin
            n_fail++; $display("FAIL col_out: valid=%b pass=%b data=%h want 1 1 %h", out_valid, out_pass, out_data, xt);
        end
        for (int i = 0; i < bp; i++) begin
            in_valid = !i[0]; in_data = rnd_frame();
            cyc();
            in_valid = 0;
            n_chk++;
            if (out_valid !== 1'b1 || out_pass !== 1'b1 || out_data !== xt || done !== 1'b0) begin
                n_fail++; $display("FAIL col_hold: valid=%b pass=%b done=%b data=%h want 1 1 0 %h",
                                   out_valid, out_pass, done, out_data, xt);
            end
        end
        out_ready = 1;
        cyc();
        out_ready = 0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        n_chk++;
        if (done !== 1'b1 || frame_cnt !== CW'(exp_cnt) || out_valid !== 1'b0 || in_ready !== 1'b1 || rt_err !== exp_err) begin
            n_fail++; $display("FAIL frame_done: done=%b cnt=%0d valid=%b in_ready=%b err=%b want 1 %0d 0 1 %b",
                               done, frame_cnt, out_valid, in_ready, rt_err, exp_cnt, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        cyc();
        n_chk++;
        if (out_valid !== 0 || out_pass !== 0 || done !== 0 || frame_cnt !== 0 || rt_err !== 0 || out_data !== '0 || in_ready !== 0) begin
            n_fail++; $display("FAIL reset_init: valid=%b pass=%b done=%b cnt=%0d err=%b in_ready=%b want all 0",
                               out_valid, out_pass, done, frame_cnt, rt_err, in_ready);
        end
        cyc();
        reset = 0;
        in_valid = 1; in_data = rnd_frame();
        cyc();
        in_valid = 0; out_ready = 1;
        cyc();
        out_ready = 0; rt_valid = 1; rt_data = rnd_frame();
        cyc();
        rt_valid = 0;
        n_chk++;
        if (out_valid !== 1'b1 || out_pass !== 1'b1) begin
            n_fail++; $display("FAIL reset_setup: valid=%b pass=%b want 1 1", out_valid, out_pass);
        end
        reset = 1;
        cyc();
        cyc();
        n_chk++;
        if (out_valid !== 0 || out_pass !== 0 || done !== 0 || frame_cnt !== 0 || rt_err !== 0 || out_data !== '0) begin
            n_fail++; $display("FAIL reset_mid: valid=%b pass=%b done=%b cnt=%0d err=%b data=%h want all 0",
                               out_valid, out_pass, done, frame_cnt, rt_err, out_data);
        end
        reset = 0; exp_cnt = 0; exp_err = 0;
        cyc();
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: in_ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_row_col_pass();
        logic [FW-1:0] f, rt;
        for (int k = 0; k < N*N; k++) begin
            f[2*k*DW +: DW]      = DW'(k);
            f[(2*k+1)*DW +: DW]  = DW'(-k);
            rt[2*k*DW +: DW]     = DW'(16'h0100 + k);
            rt[(2*k+1)*DW +: DW] = DW'(16'h0200 + k);
        end
        send_frame(f, rt, 0, 0);
        n_chk++;
        if (out_data[2*(1*N+2)*DW +: DW] !== 16'h0109 || out_data[(2*(1*N+2)+1)*DW +: DW] !== 16'h0209) begin
            n_fail++; $display("FAIL elem_1_2: re=%h im=%h want 0109 0209",
                               out_data[2*(1*N+2)*DW +: DW], out_data[(2*(1*N+2)+1)*DW +: DW]);
        end
        n_chk++;
        if (out_data[2*15*DW +: DW] !== 16'h010F || out_data[31*DW +: DW] !== 16'h020F) begin
            n_fail++; $display("FAIL elem_3_3: re=%h im=%h want 010f 020f", out_data[2*15*DW +: DW], out_data[31*DW +: DW]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 2; i++) send_frame(rnd_frame(), rnd_frame(), 5, 0);
    endtask

    task automatic test_stray_rt();
        logic [FW-1:0] prev = out_data;
        rt_valid = 1; rt_data = rnd_frame();
        cyc();
        rt_valid = 0; exp_err = 1;
        n_chk++;
        if (rt_err !== 1'b1 || out_data !== prev || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stray_idle: err=%b in_ready=%b valid=%b data=%h want 1 1 0 %h",
                               rt_err, in_ready, out_valid, out_data, prev);
        end
        send_frame(rnd_frame(), rnd_frame(), 3, 1);
    endtask

    task automatic test_back_to_back();
        int d0;
        reset = 1;
        cyc();
        reset = 0; exp_cnt = 0; exp_err = 0;
        d0 = n_done;
        for (int i = 0; i < 5; i++) send_frame(rnd_frame(), rnd_frame(), 0, 0);
        cyc();
        n_chk++;
        if (n_done - d0 != 5 || frame_cnt !== CW'(1)) begin
            n_fail++; $display("FAIL b2b_done_count: pulses=%0d cnt=%0d want 5 1", n_done - d0, frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_row_col_pass();
        test_backpressure();
        test_stray_rt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
